// File: rtl/hash_feed_sequencer.sv
// hash_feed_sequencer
//
// Read-side controller between a first-word-fall-through byte FIFO and an
// FNV hasher core. It drains framed messages from the FIFO: one header byte
// holding the payload length L, followed by L payload bytes. For each frame
// it pops the header, pulses h_start, streams the payload to the hasher,
// marks the final byte with h_last and reports completion.
//
// Optional build macro: FEED_TIMEOUT_EN
//   When defined, a message whose payload stalls (FIFO empty) for
//   TIMEOUT_CYCLES consecutive cycles is aborted with a msg_err pulse.
//   When undefined, msg_err is constant 0 and DATA waits indefinitely.
//
// Parameters:
//   DSIZE          FIFO data width / payload byte width
//   CNT_W          width of the completed-message counter
//   TIMEOUT_CYCLES stall limit in rclk cycles (FEED_TIMEOUT_EN only)
//
// Ports:
//   rclk       clock
//   rrst_n     asynchronous active-low reset
//   rempty     FIFO empty; when low, rdata holds the head word
//   rdata      FIFO head word
//   rinc       FIFO pop strobe (combinational), pops at the rclk edge
//   h_start    one-cycle pulse: new message, hasher reinitialises
//   h_valid    payload byte valid
//   h_data     payload byte
//   h_last     final byte of the message (qualified by h_valid)
//   h_ready    hasher accepts h_data when h_valid & h_ready
//   busy       high in any state other than HDR, or while h_valid is high
//   msg_done   one-cycle pulse per completed message
//   msg_err    one-cycle pulse on message abort (timeout build only)
//   msg_count  completed-message count, wraps silently
//
// Handshake: a payload byte transfers on every rclk edge where
// h_valid & h_ready. While h_valid is high and h_ready is low, h_data and
// h_last are held stable. h_valid never drops without a transfer except on
// a timeout abort.

module hash_feed_sequencer #(
    parameter int DSIZE          = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             h_start,
    output logic             h_valid,
    output logic [DSIZE-1:0] h_data,
    output logic             h_last,
    input  logic             h_ready,
    output logic             busy,
    output logic             msg_done,
    output logic             msg_err,
    output logic [CNT_W-1:0] msg_count
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] remaining;   // payload bytes still to be popped
    logic       load_ok;     // output register free (empty or draining this cycle)
    logic       hdr_pop;
    logic       data_pop;
    logic       xfer;        // payload byte accepted by the hasher this cycle

    // ------------------------------------------------------------------
    // Pop decisions. rinc is gated by rrst_n so that nothing is popped
    // while the block is held in reset, even if the FIFO is non-empty.
    // ------------------------------------------------------------------
    always_comb begin
        load_ok  = !h_valid || h_ready;
        hdr_pop  = (state == S_HDR) && !rempty;
        data_pop = (state == S_DATA) && load_ok && !rempty && (remaining != 8'd0);
        xfer     = h_valid && h_ready;
        rinc     = rrst_n && (hdr_pop || data_pop);
    end

    assign busy = (state != S_HDR) || h_valid;

`ifdef FEED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               err_q;
    logic               stalled;

    // A stall cycle is one where more payload is owed but the FIFO is empty.
    assign stalled = (state == S_DATA) && rempty && (remaining != 8'd0);
    assign msg_err = err_q;
`else
    assign msg_err = 1'b0;

    // The stall limit only matters in the timeout build.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered hasher-side outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= S_HDR;
            remaining <= 8'd0;
            h_start   <= 1'b0;
            h_valid   <= 1'b0;
            h_data    <= '0;
            h_last    <= 1'b0;
            msg_done  <= 1'b0;
            msg_count <= '0;
`ifdef FEED_TIMEOUT_EN
            stall_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses default low.
            h_start  <= 1'b0;
            msg_done <= 1'b0;
`ifdef FEED_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            case (state)
                S_HDR: begin
                    if (hdr_pop) begin
                        if (rdata == '0) begin
                            // Empty frame: completes without touching the hasher.
                            state    <= S_DONE;
                            msg_done <= 1'b1;
                        end else begin
                            remaining <= 8'(rdata);
                            h_start   <= 1'b1;
                            state     <= S_DATA;
`ifdef FEED_TIMEOUT_EN
                            stall_cnt <= '0;
`endif
                        end
                    end
                end

                S_DATA: begin
                    if (data_pop) begin
                        h_data    <= rdata;
                        h_valid   <= 1'b1;
                        h_last    <= (remaining == 8'd1);
                        remaining <= remaining - 8'd1;
                    end else if (xfer) begin
                        h_valid <= 1'b0;
                        h_last  <= 1'b0;
                    end

                    // With h_last pending, remaining is 0, so no pop can
                    // coincide with the final transfer.
                    if (xfer && h_last) begin
                        state    <= S_DONE;
                        msg_done <= 1'b1;
                    end

`ifdef FEED_TIMEOUT_EN
                    if (data_pop) begin
                        stall_cnt <= '0;
                    end else if (stalled) begin
                        if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                            // Abort: any byte still pending on h_data is dropped.
                            err_q     <= 1'b1;
                            h_valid   <= 1'b0;
                            h_last    <= 1'b0;
                            remaining <= 8'd0;
                            stall_cnt <= '0;
                            state     <= S_HDR;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
`endif
                end

                S_DONE: begin
                    msg_count <= msg_count + 1'b1;
                    state     <= S_HDR;
                end

                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_feed_sequencer.sv
// Testbench for hash_feed_sequencer: FIFO model, scoreboard of expected
// payload bytes, event monitors and directed frame scenarios.
`timescale 1ns/1ps

module tb_hash_feed_sequencer;

    localparam int DSIZE = 8;
    localparam int CNT_W = 8;     // narrow counter so the wrap is reachable quickly
    localparam int W     = DSIZE + 1;

    // ---------------- clock / reset ----------------
    logic             rclk = 1'b0;
    logic             rrst_n;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             h_start;
    logic             h_valid;
    logic [DSIZE-1:0] h_data;
    logic             h_last;
    logic             h_ready;
    logic             busy;
    logic             msg_done;
    logic             msg_err;
    logic [CNT_W-1:0] msg_count;

    always #5 rclk = ~rclk;

    hash_feed_sequencer #(
        .DSIZE(DSIZE),
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rempty(rempty),
        .rdata(rdata),
        .rinc(rinc),
        .h_start(h_start),
        .h_valid(h_valid),
        .h_data(h_data),
        .h_last(h_last),
        .h_ready(h_ready),
        .busy(busy),
        .msg_done(msg_done),
        .msg_err(msg_err),
        .msg_count(msg_count)
    );

    // ---------------- bench state ----------------
    logic [DSIZE-1:0] fifo_q[$];
    logic [W-1:0]     exp_q[$];      // {last, data}
    int               hs_log[$];     // cycles of payload transfers
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_pops = 0, n_starts = 0, n_done = 0, n_errs = 0, n_hs = 0;
    int last_pop_cyc = -1, last_done_cyc = -1, last_err_cyc = -1;
    int model_cnt = 0;
    logic         pop_now = 1'b0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge rclk) cyc <= cyc + 1;

    // ---------------- FIFO model ----------------
    function automatic void refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    always begin
        @(posedge rclk);
        #1;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_byte(input logic [DSIZE-1:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic push_payload(input logic [DSIZE-1:0] b, input logic last);
        push_byte(b);
        exp_q.push_back({last, b});
    endtask

    task automatic wait_idle(input int budget);
        bit got_idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge rclk);
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) begin
                got_idle = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(got_idle), 32'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge rclk) begin
        pop_now = rinc;
        if (rrst_n) begin
            if (rinc) begin
                n_pops++;
                last_pop_cyc = cyc;
            end
            if (h_start) begin
                n_starts++;
                check("start_with_valid", 32'(h_valid), 32'd0);
            end
            if (msg_done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (msg_err) begin
                n_errs++;
                last_err_cyc = cyc;
            end
            if (stall_prev) begin
                check("hold_valid", 32'(h_valid), 32'd1);
                check("hold_data", 32'({h_last, h_data}), 32'(stall_word));
            end
            if (h_valid && h_ready) begin
                n_hs++;
                hs_log.push_back(cyc);
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("payload", 32'({h_last, h_data}), 32'(exp_q.pop_front()));
            end
            stall_prev = h_valid && !h_ready;
            stall_word = {h_last, h_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int pat[5] = '{0, 1, 0, 0, 1};
    int s_starts, s_done, s_pops, s_hs, s_errs;

    task automatic snap();
        s_starts = n_starts;
        s_done   = n_done;
        s_pops   = n_pops;
        s_hs     = n_hs;
        s_errs   = n_errs;
    endtask

    initial begin
        rrst_n  = 1'b0;
        h_ready = 1'b0;
        refresh();

        // Reset state, with a frame already waiting in the FIFO.
        #2;
        push_byte(8'h03);
        push_payload(8'hAA, 1'b0);
        push_payload(8'hBB, 1'b0);
        push_payload(8'hCC, 1'b1);
        #20;
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_h_valid", 32'(h_valid), 32'd0);
        check("rst_h_start", 32'(h_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_msg_count", 32'(msg_count), 32'd0);
        check("rst_msg_err", 32'(msg_err), 32'd0);

        // Test 1: 03 AA BB CC with h_ready high.
        snap();
        hs_log.delete();
        step();
        rrst_n  = 1'b1;
        h_ready = 1'b1;
        wait_idle(50);
        model_cnt += 1;
        check("t1_starts", 32'(n_starts - s_starts), 32'd1);
        check("t1_done", 32'(n_done - s_done), 32'd1);
        check("t1_hs_count", 32'(hs_log.size()), 32'd3);
        if (hs_log.size() >= 3) begin
            check("t1_b_consec", 32'(hs_log[1] - hs_log[0]), 32'd1);
            check("t1_c_consec", 32'(hs_log[2] - hs_log[1]), 32'd1);
            check("t1_done_delay", 32'(last_done_cyc - hs_log[2]), 32'd1);
        end
        check("t1_msg_count", 32'(msg_count), 32'(model_cnt));

        // Test 2: 02 11 22 with h_ready pattern 0,1,0,0,1.
        snap();
        step();
        push_byte(8'h02);
        push_payload(8'h11, 1'b0);
        push_payload(8'h22, 1'b1);
        h_ready = pat[0][0];
        for (int i = 1; i < 5; i++) begin
            step();
            h_ready = pat[i][0];
        end
        step();
        h_ready = 1'b1;
        wait_idle(50);
        model_cnt += 1;
        check("t2_pops", 32'(n_pops - s_pops), 32'd3);
        check("t2_hs", 32'(n_hs - s_hs), 32'd2);
        check("t2_done", 32'(n_done - s_done), 32'd1);

        // Test 3: empty frame 00, then 01 5A.
        snap();
        step();
        push_byte(8'h00);
        wait_idle(20);
        check("t3a_starts", 32'(n_starts - s_starts), 32'd0);
        check("t3a_hs", 32'(n_hs - s_hs), 32'd0);
        check("t3a_done", 32'(n_done - s_done), 32'd1);
        snap();
        step();
        push_byte(8'h01);
        push_payload(8'h5A, 1'b1);
        wait_idle(20);
        model_cnt += 2;
        check("t3b_starts", 32'(n_starts - s_starts), 32'd1);
        check("t3b_done", 32'(n_done - s_done), 32'd1);
        check("t3_msg_count", 32'(msg_count), 32'(model_cnt));

        // Test 4: 04 01 02, long FIFO starvation, then 03 04.
        snap();
        step();
        push_byte(8'h04);
        push_payload(8'h01, 1'b0);
        push_payload(8'h02, 1'b0);
        for (int i = 0; i < 5000; i++) step();
`ifdef FEED_TIMEOUT_EN
        check("t4_err", 32'(n_errs - s_errs), 32'd1);
        check("t4_err_delay", 32'(last_err_cyc - last_pop_cyc), 32'd1025);
        check("t4_done_none", 32'(n_done - s_done), 32'd0);
        check("t4_busy_after_abort", 32'(busy), 32'd0);
        // 03 is now a header: three payload bytes follow.
        push_byte(8'h03);
        push_payload(8'h04, 1'b0);
        push_payload(8'h05, 1'b0);
        push_payload(8'h06, 1'b1);
        wait_idle(50);
        model_cnt += 1;
        check("t4_starts", 32'(n_starts - s_starts), 32'd2);
        check("t4_done", 32'(n_done - s_done), 32'd1);
`else
        check("t4_stall_busy", 32'(busy), 32'd1);
        check("t4_stall_valid", 32'(h_valid), 32'd0);
        check("t4_stall_done", 32'(n_done - s_done), 32'd0);
        push_payload(8'h03, 1'b0);
        push_payload(8'h04, 1'b1);
        wait_idle(50);
        model_cnt += 1;
        check("t4_err", 32'(n_errs - s_errs), 32'd0);
        check("t4_starts", 32'(n_starts - s_starts), 32'd1);
        check("t4_hs", 32'(n_hs - s_hs), 32'd4);
        check("t4_done", 32'(n_done - s_done), 32'd1);
`endif
        check("t4_msg_count", 32'(msg_count), 32'(model_cnt));

        // Test 5: asynchronous reset mid-DATA with a byte pending.
        step();
        h_ready = 1'b0;
        push_byte(8'h03);
        push_payload(8'hAA, 1'b0);
        push_payload(8'hBB, 1'b0);
        push_payload(8'hCC, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge rclk);
                if (h_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t5_valid_seen", 32'(seen), 32'd1);
        end
        #2;
        rrst_n = 1'b0;
        #1;
        check("t5_h_valid", 32'(h_valid), 32'd0);
        check("t5_h_data", 32'(h_data), 32'd0);
        check("t5_h_last", 32'(h_last), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rinc", 32'(rinc), 32'd0);
        check("t5_msg_count", 32'(msg_count), 32'd0);
        step();
        fifo_q.delete();
        exp_q.delete();
        refresh();
        model_cnt = 0;
        step();
        rrst_n  = 1'b1;
        h_ready = 1'b1;
        step();
        step();
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_count_after", 32'(msg_count), 32'd0);

        // Test 6: counter wrap with 01 00 frames.
        snap();
        step();
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            push_byte(8'h01);
            push_payload(8'h00, 1'b1);
        end
        wait_idle(((1 << CNT_W) - 1) * 6 + 50);
        model_cnt += (1 << CNT_W) - 1;
        check("t6_count_max", 32'(msg_count), 32'(model_cnt % (1 << CNT_W)));
        step();
        push_byte(8'h01);
        push_payload(8'h00, 1'b1);
        wait_idle(50);
        model_cnt += 1;
        check("t6_count_wrap", 32'(msg_count), 32'(model_cnt % (1 << CNT_W)));
        check("t6_done", 32'(n_done - s_done), 32'(1 << CNT_W));

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
